// File: rtl/bwt_rd_req_issue.sv
// BWT read-request issuer: buffers (k,l) address pairs, issues them as back-to-back reads
// under back-pressure and a credit limit, and re-pairs in-order responses into (k,l) pulses.
module bwt_rd_req_issue #(
  parameter int FIFO_AW         = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_W           = 6
) (
  input  logic             CLK_400M,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [57:0]      req_addr_k,
  input  logic [57:0]      req_addr_l,
  input  logic             spl_tx_rd_almostfull,
  output logic             cor_tx_rd_valid,
  output logic [57:0]      cor_tx_rd_addr,
  input  logic             io_rx_rd_valid,
  input  logic [511:0]     io_rx_data,
  output logic             rsp_valid,
  output logic [511:0]     rsp_data_k,
  output logic [511:0]     rsp_data_l,
  output logic [CNT_W-1:0] outstanding,
  output logic             rsp_overflow_err
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, SEND_L} state_t;

  state_t             state, state_nxt;
  logic [115:0]       mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [115:0]       head;
  logic               empty, full, push, issue_k, issue_l, pair_done;
  logic [57:0]        addr_l_q;
  logic               toggle;
  logic [511:0]       hold_k;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr[FIFO_AW-1:0]];
  assign pair_done = io_rx_rd_valid && toggle;

  always_ff @(posedge CLK_400M) begin
    if (push && !clear) mem[wr_ptr[FIFO_AW-1:0]] <= {req_addr_l, req_addr_k};
  end

  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n)   state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_k   = 1'b0;
    issue_l   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !spl_tx_rd_almostfull && (outstanding < MAX_CNT)) begin
          issue_k   = 1'b1;
          state_nxt = SEND_L;
        end
      end
      SEND_L: begin
        if (!spl_tx_rd_almostfull) begin
          issue_l   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      addr_l_q         <= '0;
      cor_tx_rd_valid  <= 1'b0;
      cor_tx_rd_addr   <= '0;
      toggle           <= 1'b0;
      hold_k           <= '0;
      rsp_valid        <= 1'b0;
      rsp_data_k       <= '0;
      rsp_data_l       <= '0;
      outstanding      <= '0;
      rsp_overflow_err <= 1'b0;
    end else if (clear) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      addr_l_q         <= '0;
      cor_tx_rd_valid  <= 1'b0;
      cor_tx_rd_addr   <= '0;
      toggle           <= 1'b0;
      hold_k           <= '0;
      rsp_valid        <= 1'b0;
      rsp_data_k       <= '0;
      rsp_data_l       <= '0;
      outstanding      <= '0;
      rsp_overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue_k) begin
        rd_ptr         <= rd_ptr + 1'b1;
        cor_tx_rd_addr <= head[57:0];
        addr_l_q       <= head[115:58];
      end
      if (issue_l) cor_tx_rd_addr <= addr_l_q;
      cor_tx_rd_valid <= issue_k || issue_l;

      rsp_valid <= 1'b0;
      if (io_rx_rd_valid) begin
        if (!toggle) begin
          hold_k <= io_rx_data;
          toggle <= 1'b1;
        end else begin
          rsp_data_k <= hold_k;
          rsp_data_l <= io_rx_data;
          rsp_valid  <= 1'b1;
          toggle     <= 1'b0;
        end
      end

      // A completion at zero is flagged and ignored, so the counter never wraps.
      if (pair_done && (outstanding == '0)) rsp_overflow_err <= 1'b1;
      case ({issue_k, pair_done})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_bwt_rd_req_issue.sv
// Directed self-checking bench for bwt_rd_req_issue; a second instance with a credit
// limit of 2 shares all inputs and is checked only in the credit-limit scenario.
module tb_bwt_rd_req_issue;

  logic         clk = 1'b0;
  logic         reset_n, clear, req_valid, almostfull, rx_valid;
  logic [57:0]  addr_k, addr_l;
  logic [511:0] rx_data;

  logic         req_ready, tx_valid, rsp_valid, err;
  logic [57:0]  tx_addr;
  logic [511:0] rsp_k, rsp_l;
  logic [5:0]   outst;

  logic         req_ready_b, tx_valid_b, rsp_valid_b, err_b;
  logic [57:0]  tx_addr_b;
  logic [511:0] rsp_k_b, rsp_l_b;
  logic [5:0]   outst_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] d0, d1, d2, d3;

  always #5 clk = ~clk;

  bwt_rd_req_issue dut (
    .CLK_400M(clk), .reset_n(reset_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_k(addr_k), .req_addr_l(addr_l),
    .spl_tx_rd_almostfull(almostfull),
    .cor_tx_rd_valid(tx_valid), .cor_tx_rd_addr(tx_addr),
    .io_rx_rd_valid(rx_valid), .io_rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_data_k(rsp_k), .rsp_data_l(rsp_l),
    .outstanding(outst), .rsp_overflow_err(err)
  );

  bwt_rd_req_issue #(.FIFO_AW(4), .MAX_OUTSTANDING(2), .CNT_W(6)) dut_b (
    .CLK_400M(clk), .reset_n(reset_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready_b),
    .req_addr_k(addr_k), .req_addr_l(addr_l),
    .spl_tx_rd_almostfull(almostfull),
    .cor_tx_rd_valid(tx_valid_b), .cor_tx_rd_addr(tx_addr_b),
    .io_rx_rd_valid(rx_valid), .io_rx_data(rx_data),
    .rsp_valid(rsp_valid_b), .rsp_data_k(rsp_k_b), .rsp_data_l(rsp_l_b),
    .outstanding(outst_b), .rsp_overflow_err(err_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    clear      = 1'b0;
    req_valid  = 1'b0;
    almostfull = 1'b0;
    rx_valid   = 1'b0;
    addr_k     = '0;
    addr_l     = '0;
    rx_data    = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [57:0] k, input logic [57:0] l);
    req_valid = 1'b1;
    addr_k    = k;
    addr_l    = l;
    step();
    req_valid = 1'b0;
  endtask

  task automatic beat(input logic [511:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (tx_valid !== 1'b0 || tx_addr !== '0 || rsp_valid !== 1'b0 || outst !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b addr=%h rsp=%b outst=%0d err=%b, expected all 0",
               tx_valid, tx_addr, rsp_valid, outst, err);
    end
    n_checks++;
    if (rsp_k !== '0 || rsp_l !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp_data: got k=%h l=%h expected 0", rsp_k[31:0], rsp_l[31:0]);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_issue();
    push(58'h100, 58'h200);
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_no_early_strobe: got %b expected 0", tx_valid);
    end
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_addr !== 58'h100 || outst !== 6'd1) begin
      n_fail++;
      $display("FAIL issue_k: got valid=%b addr=%h outst=%0d expected 1/100/1", tx_valid, tx_addr, outst);
    end
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_addr !== 58'h200) begin
      n_fail++;
      $display("FAIL issue_l: got valid=%b addr=%h expected 1/200", tx_valid, tx_addr);
    end
    step();
    n_checks++;
    if (tx_valid !== 1'b0 || tx_addr !== 58'h200 || outst !== 6'd1) begin
      n_fail++;
      $display("FAIL issue_idle_hold: got valid=%b addr=%h outst=%0d expected 0/200/1", tx_valid, tx_addr, outst);
    end
  endtask

  task automatic test_response();
    beat(d0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_first_beat: got rsp_valid=%b expected 0", rsp_valid);
    end
    beat(d1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_k !== d0 || rsp_l !== d1 || outst !== 6'd0) begin
      n_fail++;
      $display("FAIL rsp_pair: got valid=%b k=%h l=%h outst=%0d expected 1/%h/%h/0",
               rsp_valid, rsp_k[31:0], rsp_l[31:0], outst, d0[31:0], d1[31:0]);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_k !== d0 || rsp_l !== d1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_hold: got valid=%b k=%h l=%h err=%b expected 0/%h/%h/0",
               rsp_valid, rsp_k[31:0], rsp_l[31:0], err, d0[31:0], d1[31:0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(58'h100, 58'h200);
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_addr !== 58'h100) begin
      n_fail++;
      $display("FAIL bp_k: got valid=%b addr=%h expected 1/100", tx_valid, tx_addr);
    end
    almostfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (tx_valid !== 1'b0 || tx_addr !== 58'h100) begin
        n_fail++;
        $display("FAIL bp_stall cycle %0d: got valid=%b addr=%h expected 0/100", i, tx_valid, tx_addr);
      end
    end
    almostfull = 1'b0;
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_addr !== 58'h200) begin
      n_fail++;
      $display("FAIL bp_l_after_release: got valid=%b addr=%h expected 1/200", tx_valid, tx_addr);
    end
    step();
    n_checks++;
    if (tx_valid !== 1'b0 || outst !== 6'd1) begin
      n_fail++;
      $display("FAIL bp_no_repeat: got valid=%b outst=%0d expected 0/1", tx_valid, outst);
    end
  endtask

  task automatic test_credit_limit();
    logic [57:0] seen [8];
    int n;
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        req_valid = 1'b1;
        addr_k    = 58'(16 * (i + 1));
        addr_l    = 58'(16 * (i + 1) + 1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (tx_valid_b) begin
        if (n < 8) seen[n] = tx_addr_b;
        n++;
      end
    end
    n_checks++;
    if (n !== 4 || outst_b !== 6'd2) begin
      n_fail++;
      $display("FAIL credit_strobe_count: got %0d strobes outst=%0d expected 4/2", n, outst_b);
    end
    n_checks++;
    if (n >= 4 && (seen[0] !== 58'h10 || seen[1] !== 58'h11 || seen[2] !== 58'h20 || seen[3] !== 58'h21)) begin
      n_fail++;
      $display("FAIL credit_order: got %h %h %h %h expected 10 11 20 21", seen[0], seen[1], seen[2], seen[3]);
    end
    n = 0;
    for (int i = 0; i < 12; i++) begin
      rx_valid = (i < 2);
      rx_data  = (i == 0) ? d0 : d1;
      step();
      if (tx_valid_b) begin
        if (n < 8) seen[n] = tx_addr_b;
        n++;
      end
    end
    rx_valid = 1'b0;
    n_checks++;
    if (n !== 2 || seen[0] !== 58'h30 || seen[1] !== 58'h31 || outst_b !== 6'd2) begin
      n_fail++;
      $display("FAIL credit_third_pair: got %0d strobes first=%h second=%h outst=%0d expected 2/30/31/2",
               n, seen[0], seen[1], outst_b);
    end
  endtask

  task automatic test_full_and_overflow();
    int acc;
    do_reset();
    almostfull = 1'b1;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      req_valid = 1'b1;
      addr_k    = 58'(i);
      addr_l    = 58'(i + 100);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    n_checks++;
    if (acc !== 16 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: got accepted=%0d ready=%b expected 16/0", acc, req_ready);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || outst !== 6'd0) begin
      n_fail++;
      $display("FAIL full_no_issue: got valid=%b outst=%0d expected 0/0", tx_valid, outst);
    end
    beat(d2);
    beat(d3);
    n_checks++;
    if (err !== 1'b1 || outst !== 6'd0) begin
      n_fail++;
      $display("FAIL overflow_err: got err=%b outst=%0d expected 1/0", err, outst);
    end
    step();
    step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b expected 1", err);
    end
  endtask

  task automatic test_clear();
    int n;
    do_reset();
    almostfull = 1'b1;
    push(58'h1, 58'h2);
    push(58'h3, 58'h4);
    push(58'h5, 58'h6);
    beat(d0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    almostfull = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0 || tx_addr !== '0 || rsp_valid !== 1'b0 ||
        rsp_k !== '0 || outst !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_outputs: got ready=%b valid=%b addr=%h rsp=%b k=%h outst=%0d err=%b expected 1/0/0/0/0/0/0",
               req_ready, tx_valid, tx_addr, rsp_valid, rsp_k[31:0], outst, err);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_valid) n++;
    end
    n_checks++;
    if (n !== 0) begin
      n_fail++;
      $display("FAIL clear_fifo_empty: got %0d strobes expected 0", n);
    end
    beat(d2);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_toggle: got rsp_valid=%b after first beat expected 0", rsp_valid);
    end
    beat(d3);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_k !== d2 || rsp_l !== d3) begin
      n_fail++;
      $display("FAIL clear_repair: got valid=%b k=%h l=%h expected 1/%h/%h",
               rsp_valid, rsp_k[31:0], rsp_l[31:0], d2[31:0], d3[31:0]);
    end
  endtask

  initial begin
    d0 = {16{32'hA0A0_0001}};
    d1 = {16{32'hB1B1_0002}};
    d2 = {16{32'hC2C2_0003}};
    d3 = {16{32'hD3D3_0004}};
    test_reset();
    test_issue();
    test_response();
    test_backpressure();
    test_credit_limit();
    test_full_and_overflow();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
